wid_part_select_sequencer: RTL and testbench

- Sequences part-select extraction from a 32-bit source word, emitting it lane by lane as bytes, halfwords or a full word over a valid/ready stream.
- Sits between a wide producer and a narrow consumer; it is the controller that steps the part-select offset ([7:0], [15:8], …, [15:0], [31:16]) each cycle.
- Holds one word and supports back-to-back words with no bubble.

---
 rtl/wid_part_select_sequencer.sv | 140 ++++++++++++++
 tb/tb_wid_part_select_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wid_part_select_sequencer.sv
// Part-select sequencer: holds one source word and emits it lane by lane
// (bytes, halfwords or the full word) over a valid/ready stream, stepping the
// part-select offset once per accepted lane. Back-to-back words run bubble-free.
module wid_part_select_sequencer #(
    parameter int unsigned DATA_W    = 32,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned LANE_W   = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_last,
    input  logic              flush,
    output logic              size_err,
    output logic              busy
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    // Decoded sizes: 0 = byte, 1 = halfword, 2 = full word
    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;

    state_e              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic [1:0]          size_q;
    logic [LANE_W-1:0]   lane_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic                size_err_q;

    logic                handshake;
    logic                accept;
    logic [1:0]          dec_size;
    logic [LANE_W-1:0]   start_lane;
    logic [LANE_W-1:0]   lane_nxt;

    // Highest lane index for a decoded size
    function automatic logic [LANE_W-1:0] lane_max(input logic [1:0] sz);
        logic [LANE_W-1:0] r;
        case (sz)
            SzByte:  r = LANE_W'(DATA_W / 8 - 1);
            SzHalf:  r = LANE_W'(DATA_W / 16 - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Zero-extended part select of one lane
    function automatic logic [DATA_W-1:0] select_lane(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        sz,
                                                      input logic [LANE_W-1:0] lane);
        logic [DATA_W-1:0] r;
        int unsigned       idx;
        r   = '0;
        idx = 32'(lane);
        case (sz)
            SzByte:  r[7:0]  = word[8*idx +: 8];
            SzHalf:  r[15:0] = word[16*idx +: 16];
            default: r       = word;
        endcase
        return r;
    endfunction

    // Final lane is the top lane when counting up, lane 0 when counting down
    function automatic logic is_last(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
        return MSB_FIRST ? (lane == '0) : (lane == lane_max(sz));
    endfunction

    // Handshake, accept and next-lane decode
    always_comb begin
        handshake  = out_valid_q & out_ready;
        in_ready   = ((state_q == StIdle) | (handshake & out_last_q)) & ~flush;
        accept     = in_valid & in_ready;
        dec_size   = (in_size == 2'd3) ? 2'd2 : in_size;
        start_lane = MSB_FIRST ? lane_max(dec_size) : '0;
        lane_nxt   = MSB_FIRST ? (lane_q - 1'b1) : (lane_q + 1'b1);
    end

    // Sequencer FSM with registered outputs; flush beats accept and handshake,
    // and an accept overrides the end-of-word return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            size_q      <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            size_err_q <= 1'b0;
            if (flush) begin
                state_q     <= StIdle;
                lane_q      <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_last_q  <= 1'b0;
            end else begin
                if (handshake) begin
                    if (out_last_q) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end else begin
                        lane_q     <= lane_nxt;
                        out_data_q <= select_lane(hold_q, size_q, lane_nxt);
                        out_last_q <= is_last(size_q, lane_nxt);
                    end
                end
                if (accept) begin
                    state_q     <= StEmit;
                    hold_q      <= in_data;
                    size_q      <= dec_size;
                    lane_q      <= start_lane;
                    out_valid_q <= 1'b1;
                    out_data_q  <= select_lane(in_data, dec_size, start_lane);
                    out_last_q  <= is_last(dec_size, start_lane);
                    size_err_q  <= (in_size == 2'd3);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = lane_q;
    assign out_last  = out_last_q;
    assign size_err  = size_err_q;
    assign busy      = (state_q == StEmit);

endmodule

// File: tb/tb_wid_part_select_sequencer.sv
// Randomized and directed bench for wid_part_select_sequencer. Two instances
// (LSB-first and MSB-first) share stimulus; a queue-based model predicts the
// lane stream of each.
module tb_wid_part_select_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, flush;
    logic [DW-1:0] in_data;
    logic [1:0]    in_size;

    logic          l_in_ready, l_out_valid, l_out_last, l_size_err, l_busy;
    logic [DW-1:0] l_out_data;
    logic [1:0]    l_out_lane;
    logic          m_in_ready, m_out_valid, m_out_last, m_size_err, m_busy;
    logic [DW-1:0] m_out_data;
    logic [1:0]    m_out_lane;

    always #5 clk = ~clk;

    wid_part_select_sequencer #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .in_size(in_size), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_data(l_out_data), .out_lane(l_out_lane),
        .out_last(l_out_last), .flush(flush), .size_err(l_size_err), .busy(l_busy)
    );

    wid_part_select_sequencer #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_size(in_size), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_lane(m_out_lane),
        .out_last(m_out_last), .flush(flush), .size_err(m_size_err), .busy(m_busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    lane;
        logic          last;
    } lane_t;

    lane_t q_lsb[$];
    lane_t q_msb[$];
    bit    zero_outs;
    bit    exp_err;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expand a word into its expected lane sequence for both emission orders
    task automatic push_word(input logic [DW-1:0] w, input logic [1:0] sz);
        int            n;
        int            width;
        logic [DW-1:0] mask;
        lane_t         e;
        n     = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        width = DW / n;
        mask  = (width == DW) ? '1 : ((32'h1 << width) - 1);
        for (int k = 0; k < n; k++) begin
            e.lane = 2'(k);
            e.data = (w >> (width * k)) & mask;
            e.last = (k == n - 1);
            q_lsb.push_back(e);
            e.lane = 2'(n - 1 - k);
            e.data = (w >> (width * (n - 1 - k))) & mask;
            q_msb.push_back(e);
        end
    endtask

    // One clock cycle: apply inputs, check at negedge, advance the model
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] s,
                        input logic ordy, input logic fl, input logic r);
        bit exp_rdy;
        bit acc;
        in_valid  = v;
        in_data   = d;
        in_size   = s;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        exp_rdy = ((q_lsb.size() == 0) || (ordy && q_lsb[0].last)) && !fl;
        check("lsb_valid", 32'(l_out_valid), 32'(q_lsb.size() != 0));
        check("msb_valid", 32'(m_out_valid), 32'(q_msb.size() != 0));
        if (q_lsb.size() != 0) begin
            check("lsb_data", l_out_data, q_lsb[0].data);
            check("lsb_lane", 32'(l_out_lane), 32'(q_lsb[0].lane));
            check("lsb_last", 32'(l_out_last), 32'(q_lsb[0].last));
            check("msb_data", m_out_data, q_msb[0].data);
            check("msb_lane", 32'(m_out_lane), 32'(q_msb[0].lane));
            check("msb_last", 32'(m_out_last), 32'(q_msb[0].last));
        end else if (zero_outs) begin
            check("rst_data", l_out_data | m_out_data, '0);
            check("rst_lane", 32'(l_out_lane | m_out_lane), '0);
            check("rst_last", 32'(l_out_last | m_out_last), '0);
        end
        check("lsb_in_ready", 32'(l_in_ready), 32'(exp_rdy));
        check("msb_in_ready", 32'(m_in_ready), 32'(exp_rdy));
        check("lsb_busy", 32'(l_busy), 32'(q_lsb.size() != 0));
        check("msb_busy", 32'(m_busy), 32'(q_msb.size() != 0));
        check("lsb_size_err", 32'(l_size_err), 32'(exp_err));
        check("msb_size_err", 32'(m_size_err), 32'(exp_err));
        acc = v && exp_rdy;
        if (r) begin
            q_lsb.delete();
            q_msb.delete();
            zero_outs = 1'b1;
            exp_err   = 1'b0;
        end else if (fl) begin
            q_lsb.delete();
            q_msb.delete();
            exp_err = 1'b0;
        end else begin
            if (q_lsb.size() != 0 && ordy) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
            if (acc) begin
                push_word(d, s);
                zero_outs = 1'b0;
            end
            exp_err = acc && (s == 2'd3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 2'd0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        zero_outs = 1'b1;
        exp_err   = 1'b0;
        step(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Byte mode, LSB and MSB order
        step(1'b1, 32'hA1B2C3D4, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);
        // Halfword with backpressure
        step(1'b1, 32'h12345678, 2'd1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);
        // Back-to-back word then byte
        step(1'b1, 32'h11223344, 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h55667788, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);
        // Illegal size
        step(1'b1, 32'hCAFEF00D, 2'd3, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        // Flush after lane 1 handshake, with in_valid high
        step(1'b1, 32'hA1B2C3D4, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b1, 32'h0BADBEEF, 2'd0, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        // Reset mid-word
        step(1'b1, 32'hA1B2C3D4, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        // Flush while idle
        step(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(9) < 6, $urandom, 2'($urandom_range(3)),
                 $urandom_range(9) < 7, $urandom_range(49) == 0, $urandom_range(149) == 0);
        end
        idle(6, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
